// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: shared exception codes and trap FSM states
package trap_ctrl_pkg;
  localparam int AddrWidth = 32;
  typedef enum logic [3:0] {
    EXP_I_MISS_ALIGN = 4'd0,
    EXP_I_FAULT      = 4'd1,
    EXP_ILLEGAL      = 4'd2,
    EXP_BREAK        = 4'd3,
    EXP_L_MISS_ALIGN = 4'd4,
    EXP_L_FAULT      = 4'd5,
    EXP_S_MISS_ALIGN = 4'd6,
    EXP_S_FAULT      = 4'd7,
    EXP_ECALL_U      = 4'd8,
    EXP_ECALL_S      = 4'd9,
    EXP_ECALL_M      = 4'd11
  } ExpCode_t;
  typedef enum logic [1:0] {
    TRAP_IDLE  = 2'd0,
    TRAP_DRAIN = 2'd1,
    TRAP_REDIR = 2'd2
  } TrapState_t;
endpackage

// File: rtl/trap_ctrl_perf_cnt.sv
// perf_cnt: free-running event counter that wraps modulo 2^WIDTH
module perf_cnt #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);
  // count one event per qualifying cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: latches the first committed exception, drains, then redirects fetch
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int ADDR     = AddrWidth,
  parameter int DRAIN    = 2,
  parameter int RET_CNT  = 64,
  parameter int MISS_CNT = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                commit_e_,
  input  logic                flush_,
  input  logic [ADDR-1:0]     com_pc,
  input  logic                com_exp_,
  input  ExpCode_t            com_exp_code,
  input  logic [ADDR-1:0]     trap_vec,
  output logic                stall_,
  output logic                trap_e_,
  output logic [ADDR-1:0]     trap_pc,
  output logic [ADDR-1:0]     epc,
  output ExpCode_t            cause,
  output logic [RET_CNT-1:0]  instret,
  output logic [MISS_CNT-1:0] miss_cnt
);
  localparam int CW = $clog2(DRAIN) + 1;
  TrapState_t    state;
  logic [CW-1:0] drain;
  logic          idle_commit;
  assign idle_commit = state == TRAP_IDLE && !commit_e_;
  assign trap_pc     = trap_vec;
  // trap sequencer: first exception wins, stall through drain and redirect
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= TRAP_IDLE;
      drain   <= '0;
      stall_  <= 1'b1;
      trap_e_ <= 1'b1;
      epc     <= '0;
      cause   <= EXP_I_MISS_ALIGN;
    end else
      case (state)
        TRAP_IDLE:
          if (idle_commit && !com_exp_) begin
            state  <= TRAP_DRAIN;
            drain  <= CW'(DRAIN - 1);
            stall_ <= 1'b0;
            epc    <= com_pc;
            cause  <= com_exp_code;
          end
        TRAP_DRAIN:
          if (drain == '0) begin
            state   <= TRAP_REDIR;
            trap_e_ <= 1'b0;
          end else drain <= drain - 1'b1;
        TRAP_REDIR: begin
          state   <= TRAP_IDLE;
          trap_e_ <= 1'b1;
          stall_  <= 1'b1;
        end
        default: state <= TRAP_IDLE;
      endcase
  perf_cnt #(.WIDTH(RET_CNT)) u_instret (
    .clk  (clk),
    .reset(reset),
    .inc  (idle_commit && com_exp_),
    .cnt  (instret)
  );
  perf_cnt #(.WIDTH(MISS_CNT)) u_miss (
    .clk  (clk),
    .reset(reset),
    .inc  (idle_commit && com_exp_ && !flush_),
    .cnt  (miss_cnt)
  );
endmodule
